// File: rtl/timer_bank_pkg.sv
// Shared definitions for the multi-channel timer bank: register map,
// CTRL field positions, mode codes and channel state encoding.
package timer_bank_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_PRESC  = 2'd3;

   localparam logic [8:0] ADDR_STAT = 9'h100;
   localparam logic [8:0] ADDR_INFO = 9'h104;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_IM   = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   typedef enum logic {
      IDLE = 1'b0,
      CNT  = 1'b1
   } ch_state_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/PRESC registers, prescaler, down-counter
// and the IDLE/CNT state machine. expire pulses on the tick that finds COUNT==0.
//
//   state | meaning
//   IDLE  | stopped; COUNT frozen, loads PRESET on the edge after EN is seen
//   CNT   | prescaler running, COUNT decrements once per tick
module timer_channel
   import timer_bank_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we_ctrl,
   input  logic               we_preset,
   input  logic               we_presc,
   input  logic [3:0]         ctrl_wdata,
   input  logic [CNT_W-1:0]   preset_wdata,
   input  logic [PRESC_W-1:0] presc_wdata,
   output logic               en,
   output logic [1:0]         mode,
   output logic               im,
   output logic [CNT_W-1:0]   preset,
   output logic [CNT_W-1:0]   count,
   output logic [PRESC_W-1:0] presc,
   output logic               expire
);

   ch_state_t          state;
   logic [PRESC_W-1:0] pcnt;
   logic               tick;

   assign tick   = (pcnt == presc);
   assign expire = (state == CNT) && en && tick && (count == '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         en     <= 1'b0;
         mode   <= MODE_ONESHOT;
         im     <= 1'b0;
         preset <= '0;
         count  <= '0;
         presc  <= '0;
         pcnt   <= '0;
      end else begin
         if (we_preset) preset <= preset_wdata;
         if (we_presc)  presc  <= presc_wdata;

         case (state)
            IDLE: begin
               if (en) begin
                  state <= CNT;
                  count <= preset;
                  pcnt  <= '0;
               end
            end
            CNT: begin
               if (!en) begin
                  state <= IDLE;
               end else if (tick) begin
                  pcnt <= '0;
                  if (count != '0) begin
                     count <= count - 1'b1;
                  end else if (mode == MODE_RELOAD) begin
                     count <= preset;
                  end else begin
                     en    <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  pcnt <= pcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // Register writes land last so they override the counter's own updates.
         if (we_presc) pcnt <= '0;
         if (we_ctrl) begin
            en   <= ctrl_wdata[CTRL_EN];
            mode <= ctrl_wdata[CTRL_MODE +: 2];
            im   <= ctrl_wdata[CTRL_IM];
         end
      end
   end

endmodule

// File: rtl/timer_bank.sv
// Multi-channel programmable timer: register decode, shared W1C status,
// read mux and per-channel IRQ gating around N_CH timer_channel instances.
module timer_bank
   import timer_bank_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [8:2]      Addr,
   input  logic            WE,
   input  logic [31:0]     WData,
   output logic [31:0]     RData,
   output logic [N_CH-1:0] IRQ,
   output logic            IRQ_any
);

   logic [8:0]         byte_addr;
   logic [3:0]         ch_sel;
   logic [1:0]         reg_sel;
   logic               ch_hit;
   logic [N_CH-1:0]    stat;

   logic [N_CH-1:0]    en_v, im_v, expire_v;
   logic [1:0]         mode_v   [N_CH];
   logic [CNT_W-1:0]   preset_v [N_CH];
   logic [CNT_W-1:0]   count_v  [N_CH];
   logic [PRESC_W-1:0] presc_v  [N_CH];

   assign byte_addr = {Addr, 2'b00};
   assign ch_sel    = Addr[7:4];
   assign reg_sel   = Addr[3:2];
   assign ch_hit    = !Addr[8] && (int'(ch_sel) < N_CH);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic we_ch;
      assign we_ch = WE && ch_hit && (ch_sel == 4'(i));

      timer_channel #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_ch (
         .clk          (clk),
         .reset        (reset),
         .we_ctrl      (we_ch && (reg_sel == REG_CTRL)),
         .we_preset    (we_ch && (reg_sel == REG_PRESET)),
         .we_presc     (we_ch && (reg_sel == REG_PRESC)),
         .ctrl_wdata   (WData[3:0]),
         .preset_wdata (WData[CNT_W-1:0]),
         .presc_wdata  (WData[PRESC_W-1:0]),
         .en           (en_v[i]),
         .mode         (mode_v[i]),
         .im           (im_v[i]),
         .preset       (preset_v[i]),
         .count        (count_v[i]),
         .presc        (presc_v[i]),
         .expire       (expire_v[i])
      );
   end

   // A same-edge expiry beats the software clear.
   always_ff @(posedge clk) begin
      if (!reset)
         stat <= '0;
      else if (WE && (byte_addr == ADDR_STAT))
         stat <= (stat & ~WData[N_CH-1:0]) | expire_v;
      else
         stat <= stat | expire_v;
   end

   always_comb begin
      RData = '0;
      if (ch_hit) begin
         for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == 4'(i)) begin
               case (reg_sel)
                  REG_CTRL:   RData = 32'({im_v[i], mode_v[i], en_v[i]});
                  REG_PRESET: RData = 32'(preset_v[i]);
                  REG_COUNT:  RData = 32'(count_v[i]);
                  default:    RData = 32'(presc_v[i]);
               endcase
            end
         end
      end else if (byte_addr == ADDR_STAT) begin
         RData = 32'(stat);
      end else if (byte_addr == ADDR_INFO) begin
         RData = {8'(CNT_W), 8'h00, 8'(PRESC_W), 8'(N_CH)};
      end
   end

   assign IRQ     = stat & im_v;
   assign IRQ_any = |IRQ;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank with hand-computed expectations.
module tb_timer_bank;

   logic        clk;
   logic        reset;
   logic [8:2]  Addr;
   logic        WE;
   logic [31:0] WData;
   logic [31:0] RData;
   logic [3:0]  IRQ;
   logic        IRQ_any;

   int n_vec = 0;
   int n_err = 0;

   timer_bank dut (
      .clk     (clk),
      .reset   (reset),
      .Addr    (Addr),
      .WE      (WE),
      .WData   (WData),
      .RData   (RData),
      .IRQ     (IRQ),
      .IRQ_any (IRQ_any)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic peek(input logic [8:0] a, input logic [31:0] exp, input string tag);
      Addr = a[8:2];
      #1;
      chk(tag, RData, exp);
   endtask

   // Write lands on the next posedge; returns 1 time unit after it.
   task automatic wr(input logic [8:0] a, input logic [31:0] d);
      @(negedge clk);
      Addr  = a[8:2];
      WData = d;
      WE    = 1'b1;
      @(posedge clk);
      #1;
      WE = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      WE    = 1'b0;
      Addr  = '0;
      WData = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Reset state
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            peek(9'(16 * c + 4 * r), 32'h0, $sformatf("reset_ch%0d_reg%0d", c, r));
         end
      end
      @(negedge clk);
      peek(9'h100, 32'h0, "reset_stat");
      peek(9'h104, 32'h2000_0804, "info");
      chk("reset_irq", 32'(IRQ), 32'h0);
      chk("reset_irq_any", 32'(IRQ_any), 32'h0);

      // Channel 0 one-shot: PRESET=3, PRESC=0, EN|IM
      wr(9'h004, 32'd3);
      wr(9'h00C, 32'd0);
      wr(9'h000, 32'h9);
      Addr = 7'(9'h008 >> 2);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("ch0_count_step%0d", k), RData, 32'(3 - k));
      end
      chk("ch0_irq_before_expiry", 32'(IRQ), 32'h0);
      @(posedge clk); #1;
      chk("ch0_irq_at_expiry", 32'(IRQ), 32'h1);
      chk("ch0_irq_any", 32'(IRQ_any), 32'h1);
      peek(9'h100, 32'h1, "ch0_stat");
      peek(9'h000, 32'h8, "ch0_ctrl_en_cleared");
      peek(9'h008, 32'h0, "ch0_count_zero");
      @(posedge clk); #1;
      peek(9'h008, 32'h0, "ch0_count_stays_zero");
      wr(9'h100, 32'h1);
      peek(9'h100, 32'h0, "ch0_stat_cleared");
      chk("ch0_irq_cleared", 32'(IRQ), 32'h0);

      // Channel 1 auto-reload: PRESET=2, PRESC=1 -> period 6
      wr(9'h014, 32'd2);
      wr(9'h01C, 32'd1);
      wr(9'h010, 32'h3);
      repeat (6) @(posedge clk); #1;
      peek(9'h100, 32'h0, "ch1_stat_before_first");
      @(posedge clk); #1;
      peek(9'h100, 32'h2, "ch1_stat_first");
      chk("ch1_irq_masked", 32'(IRQ), 32'h0);
      wr(9'h100, 32'h2);
      peek(9'h100, 32'h0, "ch1_w1c");
      repeat (4) @(posedge clk); #1;
      wr(9'h100, 32'h2);
      peek(9'h100, 32'h2, "ch1_set_beats_w1c");
      wr(9'h100, 32'h2);
      peek(9'h100, 32'h0, "ch1_w1c_again");
      repeat (4) @(posedge clk); #1;
      peek(9'h100, 32'h0, "ch1_stat_before_third");
      @(posedge clk); #1;
      peek(9'h100, 32'h2, "ch1_stat_third");
      wr(9'h010, 32'h0);
      wr(9'h100, 32'h2);
      peek(9'h100, 32'h0, "ch1_stopped_cleared");

      // Channel 2 with IM=0, then unmask
      wr(9'h024, 32'd1);
      wr(9'h020, 32'h1);
      repeat (2) @(posedge clk); #1;
      peek(9'h100, 32'h0, "ch2_stat_before");
      @(posedge clk); #1;
      peek(9'h100, 32'h4, "ch2_stat_masked");
      chk("ch2_irq_masked", 32'(IRQ), 32'h0);
      chk("ch2_irq_any_masked", 32'(IRQ_any), 32'h0);
      wr(9'h020, 32'h8);
      chk("ch2_irq_unmasked", 32'(IRQ), 32'h4);
      chk("ch2_irq_any_unmasked", 32'(IRQ_any), 32'h1);
      wr(9'h100, 32'h4);
      chk("ch2_irq_any_cleared", 32'(IRQ_any), 32'h0);

      // Channel 3: PRESET rewritten mid-count, then stop
      wr(9'h034, 32'd100);
      wr(9'h03C, 32'd0);
      wr(9'h030, 32'h3);
      repeat (10) @(posedge clk); #1;
      peek(9'h038, 32'd91, "ch3_count_mid");
      wr(9'h034, 32'd5);
      peek(9'h038, 32'd90, "ch3_count_after_preset_wr");
      peek(9'h034, 32'd5, "ch3_preset_readback");
      repeat (90) @(posedge clk); #1;
      peek(9'h038, 32'd0, "ch3_count_zero");
      peek(9'h100, 32'h0, "ch3_stat_before");
      @(posedge clk); #1;
      peek(9'h038, 32'd5, "ch3_reload_new_preset");
      peek(9'h100, 32'h8, "ch3_stat");
      @(posedge clk); #1;
      peek(9'h038, 32'd4, "ch3_count_after_reload");
      wr(9'h030, 32'h0);
      peek(9'h038, 32'd3, "ch3_count_at_disable");
      repeat (3) @(posedge clk); #1;
      peek(9'h038, 32'd3, "ch3_count_frozen");

      // All channels busy, then reset mid-count
      wr(9'h004, 32'd50);
      wr(9'h000, 32'h1);
      wr(9'h024, 32'd40);
      wr(9'h020, 32'h1);
      wr(9'h030, 32'h3);
      wr(9'h010, 32'hB);
      repeat (8) @(posedge clk); #1;
      peek(9'h100, 32'hA, "pre_reset_stat");
      chk("pre_reset_irq", 32'(IRQ), 32'h2);
      peek(9'h008, 32'd39, "pre_reset_ch0_count");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++)
         peek(9'(16 * c + 8), 32'h0, $sformatf("mid_reset_ch%0d_count", c));
      peek(9'h100, 32'h0, "mid_reset_stat");
      peek(9'h010, 32'h0, "mid_reset_ch1_ctrl");
      chk("mid_reset_irq", 32'(IRQ), 32'h0);
      chk("mid_reset_irq_any", 32'(IRQ_any), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Out-of-range channel, read-only COUNT, unmapped offset
      wr(9'h054, 32'h1234);
      wr(9'h050, 32'h9);
      peek(9'h054, 32'h0, "ch5_preset");
      peek(9'h050, 32'h0, "ch5_ctrl");
      peek(9'h014, 32'h0, "ch1_preset_no_alias");
      wr(9'h008, 32'h55);
      peek(9'h008, 32'h0, "count_write_ignored");
      peek(9'h108, 32'h0, "unmapped_read");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
